// File: rtl/io_bus_rd_mux_if.sv
// Read-return bundle between the core load path and the peripheral read muxer.
// Latency: none, this file only groups signals.
// Backpressure: slaves stall a read by holding bus_rdy low. The core sees busy while the read waits.
interface io_bus_rd_mux_if #(
   parameter int NR_OF_BUSSES_IN = 4,
   parameter int BITS_PER_BUS    = 32
);
   logic                                    rd_req;
   logic [NR_OF_BUSSES_IN-1:0]              bus_sel;
   logic [NR_OF_BUSSES_IN*BITS_PER_BUS-1:0] bus_in;
   logic [NR_OF_BUSSES_IN-1:0]              bus_rdy;
   logic [BITS_PER_BUS-1:0]                 bus_out;
   logic                                    rd_valid;
   logic                                    rd_err;
   logic                                    busy;

   // Core/peripheral side: issues requests and drives slave data.
   modport master (
      output rd_req, bus_sel, bus_in, bus_rdy,
      input  bus_out, rd_valid, rd_err, busy
   );

   // Muxer side.
   modport slave (
      input  rd_req, bus_sel, bus_in, bus_rdy,
      output bus_out, rd_valid, rd_err, busy
   );
endinterface

// File: rtl/io_bus_rd_mux.sv
// Read-data return mux: selects slave data (OR-combine or lowest-index priority) and registers it.
// Latency: at least 1 cycle from rd_req to the rd_valid pulse. Each wait cycle adds 1 cycle, bounded by TIMEOUT_CYCLES.
// Backpressure: waits in WAIT (busy=1) until the selected slaves are ready. rd_req is ignored while busy.
module io_bus_rd_mux #(
   parameter int    NR_OF_BUSSES_IN = 4,
   parameter int    BITS_PER_BUS    = 32,
   parameter string USE_OR_METHOD   = "TRUE",
   parameter int    TIMEOUT_CYCLES  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   io_bus_rd_mux_if.slave bus
);

   localparam bit OR_MODE = (USE_OR_METHOD == "TRUE");
   localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam int CNT_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]                 state;
   logic [NR_OF_BUSSES_IN-1:0] sel_q;
   logic [CNT_W-1:0]           cnt;
   logic [BITS_PER_BUS-1:0]    out_q;
   logic                       vld_q;
   logic                       err_q;

   logic [NR_OF_BUSSES_IN-1:0] sel;
   logic [NR_OF_BUSSES_IN-1:0] eff_sel;
   logic [BITS_PER_BUS-1:0]    mux_data;
   logic                       mux_rdy;
   logic                       found;

   // Active select: the live request while idle, the latched one while waiting.
   // Priority mode reduces it to the lowest set bit.
   always_comb begin
      sel     = (state == ST_WAIT) ? sel_q : bus.bus_sel;
      eff_sel = '0;
      found   = 1'b0;
      if (OR_MODE) begin
         eff_sel = sel;
      end else begin
         for (int i = 0; i < NR_OF_BUSSES_IN; i++) begin
            if (!found && sel[i]) begin
               eff_sel[i] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

   // OR-combine the selected slices. The read is ready only when every selected slave is ready.
   // An empty select is never ready.
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < NR_OF_BUSSES_IN; k++) begin
         if (eff_sel[k]) begin
            mux_data = mux_data | bus.bus_in[k*BITS_PER_BUS +: BITS_PER_BUS];
         end
      end
      mux_rdy = (eff_sel != '0) && ((eff_sel & ~bus.bus_rdy) == '0);
   end

   // Control FSM and output registers. rd_valid and rd_err are single-cycle pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sel_q <= '0;
         cnt   <= '0;
         out_q <= '0;
         vld_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         err_q <= 1'b0;
         if (state == ST_IDLE) begin
            if (bus.rd_req) begin
               if (bus.bus_sel == '0) begin
                  vld_q <= 1'b1;
                  err_q <= 1'b1;
                  out_q <= '0;
               end else if (mux_rdy) begin
                  vld_q <= 1'b1;
                  out_q <= mux_data;
               end else begin
                  sel_q <= bus.bus_sel;
                  cnt   <= CNT_W'(1);
                  state <= ST_WAIT;
               end
            end
         end else begin
            // Ready takes precedence over a timeout in the same cycle.
            if (mux_rdy) begin
               vld_q <= 1'b1;
               out_q <= mux_data;
               state <= ST_IDLE;
            end else if (TO_EN && (cnt == TO_VAL)) begin
               vld_q <= 1'b1;
               err_q <= 1'b1;
               out_q <= '1;
               state <= ST_IDLE;
            end else if (cnt != '1) begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.bus_out  = out_q;
   assign bus.rd_valid = vld_q;
   assign bus.rd_err   = err_q;
   assign bus.busy     = (state == ST_WAIT);

endmodule

// File: tb/tb_io_bus_rd_mux.sv
// Directed bench for io_bus_rd_mux: one OR-mode instance (timeout 16) and one priority-mode instance (no timeout).
// Inputs are driven 1 ns after the rising edge. Outputs are checked at the same point, so they reflect that edge.
// Every mismatch is counted and reported with $error.
module tb_io_bus_rd_mux;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   logic seen_vld;

   always #5 clk = ~clk;

   io_bus_rd_mux_if #(.NR_OF_BUSSES_IN(4), .BITS_PER_BUS(32)) a ();
   io_bus_rd_mux_if #(.NR_OF_BUSSES_IN(4), .BITS_PER_BUS(32)) p ();

   io_bus_rd_mux #(
      .NR_OF_BUSSES_IN(4), .BITS_PER_BUS(32), .USE_OR_METHOD("TRUE"), .TIMEOUT_CYCLES(16)
   ) u_or (
      .clk(clk), .rst_n(rst_n), .bus(a)
   );

   io_bus_rd_mux #(
      .NR_OF_BUSSES_IN(4), .BITS_PER_BUS(32), .USE_OR_METHOD("FALSE"), .TIMEOUT_CYCLES(0)
   ) u_pri (
      .clk(clk), .rst_n(rst_n), .bus(p)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a.rd_req = 1'b0; a.bus_sel = '0; a.bus_in = '0; a.bus_rdy = '0;
      p.rd_req = 1'b0; p.bus_sel = '0; p.bus_in = '0; p.bus_rdy = '0;

      // Reset state
      #3;
      chk("rst_valid", 32'(a.rd_valid), 32'h0);
      chk("rst_err",   32'(a.rd_err),   32'h0);
      chk("rst_busy",  32'(a.busy),     32'h0);
      chk("rst_out",   a.bus_out,       32'h0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      tick();

      // Immediate read, 1-cycle latency
      a.bus_in[63:32] = 32'hDEADBEEF; a.bus_rdy = 4'b0010; a.bus_sel = 4'b0010; a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      chk("imm_valid", 32'(a.rd_valid), 32'h1);
      chk("imm_err",   32'(a.rd_err),   32'h0);
      chk("imm_data",  a.bus_out,       32'hDEADBEEF);
      chk("imm_busy",  32'(a.busy),     32'h0);
      tick();
      chk("imm_pulse", 32'(a.rd_valid), 32'h0);
      chk("imm_hold",  a.bus_out,       32'hDEADBEEF);

      // Wait states: slave 2 ready three cycles after the request
      a.bus_in[95:64] = 32'h12345678; a.bus_rdy = 4'b0000; a.bus_sel = 4'b0100; a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      chk("ws_busy1",  32'(a.busy),     32'h1);
      chk("ws_novld",  32'(a.rd_valid), 32'h0);
      tick();
      chk("ws_busy2",  32'(a.busy),     32'h1);
      tick();
      chk("ws_busy3",  32'(a.busy),     32'h1);
      a.bus_rdy = 4'b0100;
      tick();
      chk("ws_valid",  32'(a.rd_valid), 32'h1);
      chk("ws_err",    32'(a.rd_err),   32'h0);
      chk("ws_data",   a.bus_out,       32'h12345678);
      chk("ws_idle",   32'(a.busy),     32'h0);
      // Back-to-back request in the rd_valid cycle
      a.bus_sel = 4'b0010; a.bus_rdy = 4'b0110; a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      chk("b2b_valid", 32'(a.rd_valid), 32'h1);
      chk("b2b_data",  a.bus_out,       32'hDEADBEEF);

      // Timeout after 16 wait cycles
      a.bus_sel = 4'b0001; a.bus_rdy = 4'b0000; a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      repeat (15) tick();
      chk("to_early",  32'(a.rd_valid), 32'h0);
      chk("to_busy",   32'(a.busy),     32'h1);
      tick();
      chk("to_valid",  32'(a.rd_valid), 32'h1);
      chk("to_err",    32'(a.rd_err),   32'h1);
      chk("to_data",   a.bus_out,       32'hFFFFFFFF);
      chk("to_idle",   32'(a.busy),     32'h0);

      // Ready arrives exactly when cnt reaches the timeout value: data wins
      a.bus_in[31:0] = 32'hCAFEF00D; a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      repeat (15) tick();
      a.bus_rdy = 4'b0001;
      tick();
      chk("tor_valid", 32'(a.rd_valid), 32'h1);
      chk("tor_err",   32'(a.rd_err),   32'h0);
      chk("tor_data",  a.bus_out,       32'hCAFEF00D);

      // Empty select
      a.bus_sel = 4'b0000; a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      chk("emp_valid", 32'(a.rd_valid), 32'h1);
      chk("emp_err",   32'(a.rd_err),   32'h1);
      chk("emp_data",  a.bus_out,       32'h0);

      // Multi-hot select, OR mode vs priority mode
      a.bus_in = '0; a.bus_in[63:32] = 32'h0F0F0000; a.bus_in[95:64] = 32'h000000F0;
      p.bus_in = a.bus_in;
      a.bus_sel = 4'b0110; a.bus_rdy = 4'b0110; a.rd_req = 1'b1;
      p.bus_sel = 4'b0110; p.bus_rdy = 4'b0110; p.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0; p.rd_req = 1'b0;
      chk("or_valid",  32'(a.rd_valid), 32'h1);
      chk("or_data",   a.bus_out,       32'h0F0F00F0);
      chk("pri_valid", 32'(p.rd_valid), 32'h1);
      chk("pri_data",  p.bus_out,       32'h0F0F0000);

      // OR mode with only one of two selected slaves ready keeps waiting
      a.bus_rdy = 4'b0010; a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      chk("orp_busy",  32'(a.busy),     32'h1);
      chk("orp_novld", 32'(a.rd_valid), 32'h0);
      tick();
      chk("orp_busy2", 32'(a.busy),     32'h1);
      a.bus_rdy = 4'b0110;
      tick();
      chk("orp_data",  a.bus_out,       32'h0F0F00F0);

      // Priority instance has no timeout: waits indefinitely
      p.bus_in[31:0] = 32'h55AA55AA; p.bus_sel = 4'b0001; p.bus_rdy = 4'b0000; p.rd_req = 1'b1;
      tick();
      p.rd_req = 1'b0;
      seen_vld = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         seen_vld = seen_vld | p.rd_valid;
      end
      chk("nto_novld", 32'(seen_vld),   32'h0);
      chk("nto_busy",  32'(p.busy),     32'h1);
      p.bus_rdy = 4'b0001;
      tick();
      chk("nto_valid", 32'(p.rd_valid), 32'h1);
      chk("nto_data",  p.bus_out,       32'h55AA55AA);

      // Asynchronous reset in the middle of a wait
      a.bus_sel = 4'b0100; a.bus_rdy = 4'b0000; a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      tick();
      chk("ar_busy",   32'(a.busy),     32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy0",  32'(a.busy),     32'h0);
      chk("ar_out0",   a.bus_out,       32'h0);
      chk("ar_vld0",   32'(a.rd_valid), 32'h0);
      tick();
      tick();
      #2 rst_n = 1'b1;
      a.bus_rdy = 4'b0100;
      tick();
      chk("ar_novld",  32'(a.rd_valid), 32'h0);
      a.rd_req = 1'b1;
      tick();
      a.rd_req = 1'b0;
      chk("ar_valid",  32'(a.rd_valid), 32'h1);
      chk("ar_data",   a.bus_out,       32'h000000F0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/io_bus_rd_mux.md
Name: io_bus_rd_mux

Overview:
Registered, handshaked read-data return multiplexer between the core load path and N peripheral read buses. It latches the slave select on a read request and waits for the selected slave's ready. It then returns the registered data with a one-cycle valid pulse, or flags an error on an empty select or a timeout. Selection is either OR-combining or fixed-priority, set by parameter.

Parameters:
NR_OF_BUSSES_IN, 4, number of slave read buses (1..32).
BITS_PER_BUS, 32, data width per bus and of bus_out.
USE_OR_METHOD, "TRUE", "TRUE" = OR of all selected buses; "FALSE" = lowest-index selected bus wins.
TIMEOUT_CYCLES, 16, WAIT cycles before timeout error; 0 disables timeout.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rd_req  in  1  read request, sampled only in IDLE.
bus_sel  in  NR_OF_BUSSES_IN  one-hot (or multi-hot) slave select, sampled with rd_req.
bus_in  in  NR_OF_BUSSES_IN*BITS_PER_BUS  concatenated slave data; slave k occupies bits [k*BITS_PER_BUS +: BITS_PER_BUS].
bus_rdy  in  NR_OF_BUSSES_IN  per-slave data-ready.
bus_out  out  BITS_PER_BUS  registered read data.
rd_valid  out  1  one-cycle pulse: bus_out/rd_err valid.
rd_err  out  1  qualifies rd_valid: empty select or timeout.
busy  out  1  high while in WAIT.

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, sel_q=0, cnt=0, bus_out=0, rd_valid=0, rd_err=0, busy=0. Reset mid-WAIT aborts the transaction silently, with no rd_valid.
- Effective select eff_sel:
  - OR mode: eff_sel = sel.
  - Priority mode: eff_sel is the lowest set bit of sel.
  - In IDLE, sel = bus_sel. In WAIT, sel = sel_q.
- Return data: OR of bus_in slices whose eff_sel bit is set.
- Ready:
  - OR mode: every eff_sel bit has bus_rdy set.
  - Priority mode: the chosen slave's bus_rdy is set.
- rd_valid and rd_err default to 0 every cycle; they are pulses only.
- IDLE, when rd_req=1:
  - bus_sel==0: next cycle rd_valid=1, rd_err=1, bus_out=0; stay IDLE.
  - Else, ready this cycle: capture data into bus_out; next cycle rd_valid=1, rd_err=0; stay IDLE. Minimum latency is 1 cycle.
  - Else: sel_q<=bus_sel, cnt<=1, go to WAIT, busy=1 from the next cycle.
- IDLE, when rd_req=0: outputs hold; bus_out retains the last value.
- WAIT, evaluated every cycle:
  - Ready: capture data; next cycle rd_valid=1, rd_err=0, state IDLE, busy=0.
  - Else, TIMEOUT_CYCLES!=0 and cnt==TIMEOUT_CYCLES: next cycle rd_valid=1, rd_err=1, bus_out={BITS_PER_BUS{1'b1}}, state IDLE.
  - Else: cnt<=cnt+1.
  - Ready and timeout in the same cycle: ready wins, no error.
  - rd_req during WAIT is ignored.
- Back-to-back: the rd_valid cycle is an IDLE cycle, so a new rd_req is accepted in that same cycle.
- cnt width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit. With TIMEOUT_CYCLES=0, cnt saturates and never times out.
- bus_in and bus_rdy are sampled only at capture; changes outside capture have no effect.

Test Plan:
- Immediate read: N=4, rd_req with bus_sel=0010, bus_rdy=0010, slice1=0xDEADBEEF -> next cycle rd_valid=1, rd_err=0, bus_out=0xDEADBEEF, busy never high.
- Wait states: bus_sel=0100, bus_rdy[2] rises 3 cycles after request with slice2=0x12345678 -> busy high 3 cycles, rd_valid on the cycle after rdy, data=0x12345678, then a back-to-back rd_req in that cycle is accepted.
- Timeout: TIMEOUT_CYCLES=16, bus_sel=0001, bus_rdy=0 -> rd_valid=1, rd_err=1, bus_out=0xFFFFFFFF at cycle 17 after request. Also rdy asserted exactly at cnt==16 -> no error, data returned.
- Empty select: rd_req with bus_sel=0000 -> next cycle rd_valid=1, rd_err=1, bus_out=0.
- Multi-hot select, bus_sel=0110, slice1=0x0F0F0000, slice2=0x000000F0, both ready:
  - OR mode -> 0x0F0F00F0.
  - Priority mode -> 0x0F0F0000.
  - OR mode with only rdy[1] set -> stays in WAIT.
- Reset mid-WAIT: assert rst_n=0 asynchronously during WAIT -> all outputs 0 immediately; after release no rd_valid, next rd_req served normally.
